alu_ctrl_seq: RTL
=================

// Module: alu_ctrl_seq
// PURPOSE
// - Registered, handshaked successor to the combinational ALU operation decoder in the ID/EX path.
// - Decodes alu_op/funct3/funct7 into a widened operation code: R/I-type, shifts, SLT(U) and unsigned branches.
// - Holds the result in one output stage with valid/ready.
// - Optionally sequences multi-cycle M-extension ops, stalling upstream until the MDU latency elapses.
// PARAMETERS
// - OP_W        5   operation code width (>=5; codes zero-extended)
// - MUL_CYCLES  2   cycles from accept to out_valid for MUL* (>=1)
// - DIV_CYCLES  32  cycles from accept to out_valid for DIV*/REM* (>=1)
// PORTS
// - clk        in   1     clock; all state updates on rising edge
// - reset      in   1     synchronous, active-high reset
// - flush      in   1     sync drop of held/in-flight op (branch mispredict)
// - in_valid   in   1     decode request valid
// - in_ready   out  1     request accepted when in_valid & in_ready
// - alu_op     in   3     000 ld/st, 001 branch, 010 R-type, 011 I-type ALU, 100 pass/LUI
// - funct7     in   7     instr[31:25]
// - funct3     in   3     instr[14:12]
// - out_valid  out  1     operation/illegal/mdu_op valid
// - out_ready  in   1     downstream accepts when out_valid & out_ready
// - operation  out  OP_W  ALU/MDU op code
// - illegal    out  1     unsupported combination decoded
// - mdu_op     out  1     held op is a multiply/divide op
// BEHAVIOUR
// - Codes:
//   - AND 00000, SUB 00001, ADD 00010, BNE 00011, OR 00100, XOR 00101, BGE 00110, BLT 00111.
//   - BEQ 01000, SLL 01001, SRL 01010, SRA 01011, SLT 01100, SLTU 01101, BLTU 01110, BGEU 01111.
//   - MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
// - Decode by alu_op:
//   - ld/st and pass -> ADD.
//   - branch funct3 000/001/100/101/110/111 -> BEQ/BNE/BLT/BGE/BLTU/BGEU.
//   - R-type: funct7 0000000 or 0100000 (SUB, SRA only) per RV32I.
//   - I-type: funct7 ignored except shifts (SRAI needs 0100000, SLLI/SRLI need 0000000).
//   - Any other combination -> operation=0, illegal=1, mdu_op=0.
// - FSM states:
//   - EMPTY: in_ready=1; on accept go FULL, or MDU if mdu op with CYCLES>=2.
//   - FULL: out_valid=1; in_ready=out_ready.
//     - out_ready & ~in_valid -> EMPTY.
//     - out_ready & in_valid -> accept back-to-back, re-enter FULL/MDU.
//   - MDU: in_ready=0, out_valid=0; cnt decrements each cycle; cnt==1 -> FULL.
// - Counter:
//   - On accept, cnt <= CYCLES-1 (MUL_CYCLES or DIV_CYCLES, CYCLES>=2).
//   - CYCLES==1 goes straight to FULL.
// - Latency:
//   - Non-MDU accept at edge N -> out_valid in cycle N+1.
//   - MDU -> out_valid in cycle N+CYCLES.
// - Held outputs stay stable while out_valid & ~out_ready.
// - Priority: reset > flush > handshakes.
//   - Flush forces EMPTY and clears cnt.
//   - In-cycle in_valid is not accepted (in_ready=0 while flush=1).
// - Reset values: out_valid=0, operation=0, illegal=0, mdu_op=0, cnt=0, state EMPTY, in_ready=1 from next cycle.
// - Reset or flush mid-MDU aborts with no output.
// - No simulation-only prints.
// CONFIGURATION
// - ALU_CTRL_MDU_EN defined:
//   - R-type with funct7 0000001 decodes to the MUL/DIV codes above.
//   - mdu_op=1; MDU state is used.
// - ALU_CTRL_MDU_EN undefined:
//   - funct7 0000001 -> illegal=1, operation=0, 1-cycle latency.
//   - MDU state and counter are not built; mdu_op tied 0.
// TESTING
// - Reset: reset=1 for 2 cycles mid-traffic -> out_valid=0, operation=0, illegal=0; in_ready=1 after release.
// - R-type SUB: alu_op=010, f3=000, f7=0100000 -> next cycle operation=00001, illegal=0.
//   - Back-to-back I-type SRAI f3=101, f7=0100000 -> 01011.
// - Branches: f3=110 -> 01110, f3=010 -> operation=0, illegal=1.
//   - Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
// - MDU_EN, DIV_CYCLES=32, f7=0000001, f3=100 -> in_ready=0 for 31 cycles.
//   - out_valid 32 cycles after accept, operation=10100, mdu_op=1.
// - MDU_EN, flush at cycle 10 of DIV -> no out_valid; EMPTY next cycle; following ADD emerges 1 cycle after accept.
// - No MDU_EN: f7=0000001, f3=000 -> illegal=1, operation=0, 1-cycle latency, mdu_op=0.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Registered ALU/MDU operation decoder with a single valid/ready output stage.
// Define ALU_CTRL_MDU_EN to decode M-extension ops and stall for their latency.
module alu_ctrl_seq #(
  parameter int OP_W       = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] operation,
  output logic            illegal,
  output logic            mdu_op
);

  // state  | meaning
  // EMPTY  | no held op, ready for a request
  // FULL   | decoded op presented downstream
  // MDU    | multi-cycle op in flight, upstream stalled
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
`ifdef ALU_CTRL_MDU_EN
  localparam logic [1:0] S_MDU   = 2'd2;
`endif

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_BNE  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_BGE  = 5'b00110;
  localparam logic [4:0] OP_BLT  = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b01001;
  localparam logic [4:0] OP_SRL  = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01011;
  localparam logic [4:0] OP_SLT  = 5'b01100;
  localparam logic [4:0] OP_SLTU = 5'b01101;
  localparam logic [4:0] OP_BLTU = 5'b01110;
  localparam logic [4:0] OP_BGEU = 5'b01111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [1:0]      state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            ill_q, ill_d;
  logic [4:0]      dec_code;
  logic            dec_ill;
  logic            accept;

  // funct3 -> op for the shared R/I arithmetic group (funct7 checked by caller)
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

`ifdef ALU_CTRL_MDU_EN
  localparam int MAX_C = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAX_C > 2) ? $clog2(MAX_C) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdu_q, mdu_d;
  logic             dec_mdu;
  logic             dec_multi;
`endif

  always_comb begin
    dec_code = OP_ADD;
    dec_ill  = 1'b0;
`ifdef ALU_CTRL_MDU_EN
    dec_mdu  = 1'b0;
`endif
    case (alu_op)
      3'b000, 3'b100: dec_code = OP_ADD;
      3'b001: begin
        case (funct3)
          3'b000:  dec_code = OP_BEQ;
          3'b001:  dec_code = OP_BNE;
          3'b100:  dec_code = OP_BLT;
          3'b101:  dec_code = OP_BGE;
          3'b110:  dec_code = OP_BLTU;
          3'b111:  dec_code = OP_BGEU;
          default: dec_ill  = 1'b1;
        endcase
      end
      3'b010: begin
        if (funct7 == F7_BASE)
          dec_code = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)
          dec_code = OP_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)
          dec_code = OP_SRA;
`ifdef ALU_CTRL_MDU_EN
        else if (funct7 == 7'b0000001) begin
          dec_code = {2'b10, funct3};
          dec_mdu  = 1'b1;
        end
`endif
        else
          dec_ill = 1'b1;
      end
      3'b011: begin
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) dec_code = OP_SLL;
            else                   dec_ill  = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec_code = OP_SRL;
            else if (funct7 == F7_ALT) dec_code = OP_SRA;
            else                       dec_ill  = 1'b1;
          end
          default: dec_code = base_op(funct3);
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec_code = 5'd0;
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_EMPTY: in_ready = 1'b1;
      S_FULL:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready & ~flush & ~reset;
  end

  assign accept = in_valid & in_ready;

`ifdef ALU_CTRL_MDU_EN
  // funct3[2] separates DIV/REM from MUL; single-cycle units skip the MDU state
  assign dec_multi = dec_mdu & (funct3[2] ? (DIV_CYCLES >= 2) : (MUL_CYCLES >= 2));
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ill_d   = ill_q;
`ifdef ALU_CTRL_MDU_EN
    cnt_d   = cnt_q;
    mdu_d   = mdu_q;
`endif
    if (accept) begin
      op_d    = OP_W'(dec_code);
      ill_d   = dec_ill;
      state_d = S_FULL;
`ifdef ALU_CTRL_MDU_EN
      mdu_d   = dec_mdu;
      if (dec_multi) begin
        state_d = S_MDU;
        cnt_d   = funct3[2] ? DIV_LOAD : MUL_LOAD;
      end
`endif
    end else begin
      case (state_q)
        S_FULL: if (out_ready) state_d = S_EMPTY;
`ifdef ALU_CTRL_MDU_EN
        S_MDU: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FULL;
        end
`endif
        default: state_d = state_q;
      endcase
    end
    if (flush) begin
      state_d = S_EMPTY;
`ifdef ALU_CTRL_MDU_EN
      cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      op_q    <= '0;
      ill_q   <= 1'b0;
`ifdef ALU_CTRL_MDU_EN
      cnt_q   <= '0;
      mdu_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
`ifdef ALU_CTRL_MDU_EN
      cnt_q   <= cnt_d;
      mdu_q   <= mdu_d;
`endif
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign operation = op_q;
  assign illegal   = ill_q;
`ifdef ALU_CTRL_MDU_EN
  assign mdu_op    = mdu_q;
`else
  assign mdu_op    = 1'b0;
`endif

endmodule
